// File: rtl/axi_rd_arbiter.sv
// Two-port round-robin read arbiter sharing one AXI4 AR/R master port.
// Only one transaction is outstanding at a time. The grant is held from AR
// acceptance until the rlast beat completes, so IDs pass through untouched.
module axi_rd_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic [ADDR_WIDTH-1:0] s0_axi_araddr,
    input  logic [ID_WIDTH-1:0]   s0_axi_arid,
    input  logic [7:0]            s0_axi_arlen,
    input  logic [2:0]            s0_axi_arsize,
    input  logic [1:0]            s0_axi_arburst,
    input  logic [2:0]            s0_axi_arprot,
    input  logic                  s0_axi_arvalid,
    output logic                  s0_axi_arready,
    output logic [DATA_WIDTH-1:0] s0_axi_rdata,
    output logic [ID_WIDTH-1:0]   s0_axi_rid,
    output logic [1:0]            s0_axi_rresp,
    output logic                  s0_axi_rlast,
    output logic                  s0_axi_rvalid,
    input  logic                  s0_axi_rready,

    input  logic [ADDR_WIDTH-1:0] s1_axi_araddr,
    input  logic [ID_WIDTH-1:0]   s1_axi_arid,
    input  logic [7:0]            s1_axi_arlen,
    input  logic [2:0]            s1_axi_arsize,
    input  logic [1:0]            s1_axi_arburst,
    input  logic [2:0]            s1_axi_arprot,
    input  logic                  s1_axi_arvalid,
    output logic                  s1_axi_arready,
    output logic [DATA_WIDTH-1:0] s1_axi_rdata,
    output logic [ID_WIDTH-1:0]   s1_axi_rid,
    output logic [1:0]            s1_axi_rresp,
    output logic                  s1_axi_rlast,
    output logic                  s1_axi_rvalid,
    input  logic                  s1_axi_rready,

    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    typedef enum logic [1:0] {StIdle, StAr, StR} state_e;

    state_e state_q;
    logic   grant_q;
    logic   last_grant_q;
    logic   sel;
    logic   any_valid;

    // Round-robin pick: a lone requester wins, otherwise the one not served last.
    always_comb begin
        any_valid = s0_axi_arvalid | s1_axi_arvalid;
        if (s0_axi_arvalid && s1_axi_arvalid) begin
            sel = ~last_grant_q;
        end else begin
            sel = s1_axi_arvalid;
        end
    end

    // Upstream AR ready; outputs are also held low while reset is asserted.
    always_comb begin
        s0_axi_arready = 1'b0;
        s1_axi_arready = 1'b0;
        if (rst_n && state_q == StIdle) begin
            s0_axi_arready = s0_axi_arvalid & ~sel;
            s1_axi_arready = s1_axi_arvalid & sel;
        end
    end

    // Zero-latency R channel steering to the granted port only.
    always_comb begin
        s0_axi_rdata  = '0;
        s0_axi_rid    = '0;
        s0_axi_rresp  = '0;
        s0_axi_rlast  = 1'b0;
        s0_axi_rvalid = 1'b0;
        s1_axi_rdata  = '0;
        s1_axi_rid    = '0;
        s1_axi_rresp  = '0;
        s1_axi_rlast  = 1'b0;
        s1_axi_rvalid = 1'b0;
        m_axi_rready  = 1'b0;
        if (rst_n && state_q == StR) begin
            if (grant_q) begin
                s1_axi_rdata  = m_axi_rdata;
                s1_axi_rid    = m_axi_rid;
                s1_axi_rresp  = m_axi_rresp;
                s1_axi_rlast  = m_axi_rlast;
                s1_axi_rvalid = m_axi_rvalid;
                m_axi_rready  = s1_axi_rready;
            end else begin
                s0_axi_rdata  = m_axi_rdata;
                s0_axi_rid    = m_axi_rid;
                s0_axi_rresp  = m_axi_rresp;
                s0_axi_rlast  = m_axi_rlast;
                s0_axi_rvalid = m_axi_rvalid;
                m_axi_rready  = s0_axi_rready;
            end
        end
    end

    // Arbitration FSM with registered downstream AR payload and valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            grant_q       <= 1'b0;
            last_grant_q  <= 1'b1;
            m_axi_arvalid <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arid    <= '0;
            m_axi_arlen   <= '0;
            m_axi_arsize  <= '0;
            m_axi_arburst <= '0;
            m_axi_arprot  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (any_valid) begin
                        if (sel) begin
                            m_axi_araddr  <= s1_axi_araddr;
                            m_axi_arid    <= s1_axi_arid;
                            m_axi_arlen   <= s1_axi_arlen;
                            m_axi_arsize  <= s1_axi_arsize;
                            m_axi_arburst <= s1_axi_arburst;
                            m_axi_arprot  <= s1_axi_arprot;
                        end else begin
                            m_axi_araddr  <= s0_axi_araddr;
                            m_axi_arid    <= s0_axi_arid;
                            m_axi_arlen   <= s0_axi_arlen;
                            m_axi_arsize  <= s0_axi_arsize;
                            m_axi_arburst <= s0_axi_arburst;
                            m_axi_arprot  <= s0_axi_arprot;
                        end
                        m_axi_arvalid <= 1'b1;
                        grant_q       <= sel;
                        last_grant_q  <= sel;
                        state_q       <= StAr;
                    end
                end
                StAr: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        state_q       <= StR;
                    end
                end
                StR: begin
                    // Only rlast ends the burst; error responses are forwarded as-is.
                    if (m_axi_rvalid && m_axi_rready && m_axi_rlast) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: table-driven contention run plus
// hand-written sequences for backpressure, error response and mid-burst reset.
module tb_axi_rd_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] s0_araddr, s1_araddr, m_araddr;
    logic [3:0]  s0_arid, s1_arid, m_arid;
    logic [7:0]  s0_arlen, s1_arlen, m_arlen;
    logic [2:0]  s0_arsize, s1_arsize, m_arsize;
    logic [1:0]  s0_arburst, s1_arburst, m_arburst;
    logic [2:0]  s0_arprot, s1_arprot, m_arprot;
    logic        s0_arvalid, s1_arvalid, m_arvalid;
    logic        s0_arready, s1_arready, m_arready;
    logic [31:0] s0_rdata, s1_rdata, m_rdata;
    logic [3:0]  s0_rid, s1_rid, m_rid;
    logic [1:0]  s0_rresp, s1_rresp, m_rresp;
    logic        s0_rlast, s1_rlast, m_rlast;
    logic        s0_rvalid, s1_rvalid, m_rvalid;
    logic        s0_rready, s1_rready, m_rready;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    axi_rd_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .s0_axi_araddr(s0_araddr), .s0_axi_arid(s0_arid), .s0_axi_arlen(s0_arlen),
        .s0_axi_arsize(s0_arsize), .s0_axi_arburst(s0_arburst), .s0_axi_arprot(s0_arprot),
        .s0_axi_arvalid(s0_arvalid), .s0_axi_arready(s0_arready),
        .s0_axi_rdata(s0_rdata), .s0_axi_rid(s0_rid), .s0_axi_rresp(s0_rresp),
        .s0_axi_rlast(s0_rlast), .s0_axi_rvalid(s0_rvalid), .s0_axi_rready(s0_rready),
        .s1_axi_araddr(s1_araddr), .s1_axi_arid(s1_arid), .s1_axi_arlen(s1_arlen),
        .s1_axi_arsize(s1_arsize), .s1_axi_arburst(s1_arburst), .s1_axi_arprot(s1_arprot),
        .s1_axi_arvalid(s1_arvalid), .s1_axi_arready(s1_arready),
        .s1_axi_rdata(s1_rdata), .s1_axi_rid(s1_rid), .s1_axi_rresp(s1_rresp),
        .s1_axi_rlast(s1_rlast), .s1_axi_rvalid(s1_rvalid), .s1_axi_rready(s1_rready),
        .m_axi_araddr(m_araddr), .m_axi_arid(m_arid), .m_axi_arlen(m_arlen),
        .m_axi_arsize(m_arsize), .m_axi_arburst(m_arburst), .m_axi_arprot(m_arprot),
        .m_axi_arvalid(m_arvalid), .m_axi_arready(m_arready),
        .m_axi_rdata(m_rdata), .m_axi_rid(m_rid), .m_axi_rresp(m_rresp),
        .m_axi_rlast(m_rlast), .m_axi_rvalid(m_rvalid), .m_axi_rready(m_rready)
    );

    // One cycle-level vector; exp = {s0_arready, s1_arready, m_arvalid,
    // s0_rvalid, s1_rvalid, m_rready} sampled just before the rising edge.
    typedef struct {
        bit          rst;
        bit          a0, a1, arr, rv, rl, rr0, rr1;
        logic [5:0]  exp;
        bit          chk_addr;
        logic [31:0] e_addr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit rst, bit a0, bit a1, bit arr, bit rv, bit rl,
                                bit rr0, bit rr1, logic [5:0] e, bit ca, logic [31:0] ea);
        vec_t v;
        v.rst = rst; v.a0 = a0; v.a1 = a1; v.arr = arr; v.rv = rv; v.rl = rl;
        v.rr0 = rr0; v.rr1 = rr1; v.exp = e; v.chk_addr = ca; v.e_addr = ea;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int beats;
        bit rr;

        rst_n = 1'b0;
        s0_araddr = 32'h100; s0_arid = 4'd1; s0_arlen = 8'd3; s0_arsize = 3'd2;
        s0_arburst = 2'b01; s0_arprot = 3'd0; s0_arvalid = 1'b0; s0_rready = 1'b1;
        s1_araddr = 32'h200; s1_arid = 4'd2; s1_arlen = 8'd3; s1_arsize = 3'd2;
        s1_arburst = 2'b01; s1_arprot = 3'd0; s1_arvalid = 1'b0; s1_rready = 1'b1;
        m_arready = 1'b0; m_rdata = '0; m_rid = 4'd0; m_rresp = 2'b00;
        m_rlast = 1'b0; m_rvalid = 1'b0;
        tick();

        // Reset held with both requesting, then 4 contended bursts of 4 beats.
        for (int r = 0; r < 3; r++) vecs.push_back(mk(0, 1, 1, 1, 0, 0, 1, 1, 6'b000000, 0, 0));
        for (int t = 0; t < 4; t++) begin
            bit p;
            p = t[0];
            vecs.push_back(mk(1, 1, 1, 1, 0, 0, 1, 1, p ? 6'b010000 : 6'b100000, 0, 0));
            vecs.push_back(mk(1, 1, 1, 1, 0, 0, 1, 1, 6'b001000, 1, p ? 32'h200 : 32'h100));
            for (int b = 0; b < 4; b++)
                vecs.push_back(mk(1, 1, 1, 1, 1, b == 3, 1, 1,
                                  p ? 6'b000011 : 6'b000101, 0, 0));
        end
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 1, 1, 6'b000000, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            rst_n = vecs[i].rst; s0_arvalid = vecs[i].a0; s1_arvalid = vecs[i].a1;
            m_arready = vecs[i].arr; m_rvalid = vecs[i].rv; m_rlast = vecs[i].rl;
            s0_rready = vecs[i].rr0; s1_rready = vecs[i].rr1;
            m_rdata = 32'hA000_0000 + i;
            #1;
            chk($sformatf("vec%0d_flags", i),
                {58'd0, s0_arready, s1_arready, m_arvalid, s0_rvalid, s1_rvalid, m_rready},
                {58'd0, vecs[i].exp});
            if (vecs[i].chk_addr) chk($sformatf("vec%0d_araddr", i), m_araddr, vecs[i].e_addr);
            if (vecs[i].exp[2]) begin
                chk($sformatf("vec%0d_s0_rdata", i), s0_rdata, 32'hA000_0000 + i);
                chk($sformatf("vec%0d_s1_rdata_idle", i), s1_rdata, 0);
            end
            if (vecs[i].exp[1]) begin
                chk($sformatf("vec%0d_s1_rdata", i), s1_rdata, 32'hA000_0000 + i);
                chk($sformatf("vec%0d_s1_rlast", i), s1_rlast, vecs[i].rl);
            end
            tick();
        end

        // Single s1 request, single beat.
        s0_arvalid = 0; s1_arvalid = 1; s1_araddr = 32'h1000; s1_arid = 4'd3; s1_arlen = 8'd0;
        m_arready = 1; m_rvalid = 0; m_rlast = 0;
        #1;
        chk("single_s1_arready", s1_arready, 1);
        chk("single_arvalid_pre", m_arvalid, 0);
        tick();
        s1_arvalid = 0;
        #1;
        chk("single_arvalid", m_arvalid, 1);
        chk("single_araddr", m_araddr, 32'h1000);
        chk("single_arid", m_arid, 3);
        chk("single_arlen", m_arlen, 0);
        tick();
        chk("single_arvalid_drop", m_arvalid, 0);
        m_rvalid = 1; m_rdata = 32'hDEADBEEF; m_rlast = 1; m_rid = 4'd3; s1_rready = 1;
        #1;
        chk("single_s1_rvalid", s1_rvalid, 1);
        chk("single_s1_rdata", s1_rdata, 32'hDEADBEEF);
        chk("single_s1_rid", s1_rid, 3);
        chk("single_s0_rvalid", s0_rvalid, 0);
        chk("single_m_rready", m_rready, 1);
        tick();
        chk("single_back_idle", {s1_rvalid, m_rready}, 2'b00);
        m_rvalid = 0; m_rlast = 0;

        // AR backpressure, then R with toggling s0_rready.
        s0_arvalid = 1; s0_araddr = 32'h2000; s0_arlen = 8'd3; m_arready = 0;
        #1;
        chk("bp_s0_arready", s0_arready, 1);
        tick();
        s0_arvalid = 0; s0_araddr = 32'hFFFF_0000;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("bp_hold_arvalid%0d", k), m_arvalid, 1);
            chk($sformatf("bp_hold_araddr%0d", k), m_araddr, 32'h2000);
            chk($sformatf("bp_rready%0d", k), m_rready, 0);
            tick();
        end
        m_arready = 1;
        tick();
        m_arready = 0;
        beats = 0;
        m_rvalid = 1;
        for (int k = 0; k < 12 && beats < 4; k++) begin
            rr = (k < 4) ? ~k[0] : 1'b1;
            s0_rready = rr; m_rdata = 32'h5000 + beats; m_rlast = (beats == 3);
            #1;
            chk($sformatf("bp_mirror%0d", k), m_rready, rr);
            chk($sformatf("bp_rdata%0d", k), s0_rdata, 32'h5000 + beats);
            tick();
            if (rr) beats++;
        end
        chk("bp_beats", beats, 4);
        #1;
        chk("bp_idle", {s0_rvalid, m_rready}, 2'b00);
        m_rvalid = 0; m_rlast = 0; s0_rready = 1;

        // Error response on beat 0 must not end the burst.
        s1_arvalid = 1; s1_arlen = 8'd1; m_arready = 1;
        tick();
        s1_arvalid = 0;
        tick();
        m_rvalid = 1; m_rresp = 2'b10; m_rlast = 0;
        #1;
        chk("err_b0_rresp", s1_rresp, 2'b10);
        chk("err_b0_rvalid", s1_rvalid, 1);
        tick();
        m_rresp = 2'b00; m_rlast = 1;
        #1;
        chk("err_b1_still_r", s1_rvalid, 1);
        chk("err_b1_rlast", s1_rlast, 1);
        tick();
        chk("err_idle", {s1_rvalid, m_rready}, 2'b00);
        m_rvalid = 0; m_rlast = 0;

        // Reset after the first of four beats, then a fresh request.
        s0_arvalid = 1; s0_araddr = 32'h3000; s0_arlen = 8'd3;
        tick();
        s0_arvalid = 0;
        tick();
        m_rvalid = 1; m_rlast = 0;
        tick();
        rst_n = 0;
        #1;
        chk("rst_mid_rready", m_rready, 0);
        chk("rst_mid_rvalid", s0_rvalid, 0);
        tick();
        rst_n = 1;
        #1;
        chk("rst_after_idle", {s0_rvalid, s1_rvalid, m_rready, m_arvalid}, 4'b0000);
        m_rvalid = 0;
        s0_arvalid = 1; s1_arvalid = 1; s0_araddr = 32'h4000; s0_arlen = 8'd0;
        #1;
        chk("rst_fresh_port0_wins", {s0_arready, s1_arready}, 2'b10);
        tick();
        s0_arvalid = 0; s1_arvalid = 0;
        chk("rst_fresh_araddr", m_araddr, 32'h4000);
        tick();
        m_rvalid = 1; m_rlast = 1; m_rdata = 32'h1234_5678;
        #1;
        chk("rst_fresh_rdata", s0_rdata, 32'h1234_5678);
        tick();
        chk("rst_fresh_idle", {s0_rvalid, m_rready}, 2'b00);
        m_rvalid = 0; m_rlast = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Two-requester round-robin arbiter that shares one AXI4 read master port, e.g. the AR/R channels into the read clock-domain crossing, between instruction fetch and data load.
- Allows one outstanding transaction at a time. The grant is held from AR acceptance until the final R beat (rlast) completes, so no ID remapping or reorder buffering is needed.
- Single clock domain; sits on the core side of the read CDC.

Parameters:
DATA_WIDTH, 32, read data width in bits
ADDR_WIDTH, 32, address width in bits
ID_WIDTH, 4, AXI ID width; passed through unchanged

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
s{0,1}_axi_araddr  in  ADDR_WIDTH  requester read address
s{0,1}_axi_arid  in  ID_WIDTH  requester ID
s{0,1}_axi_arlen  in  8  burst length minus one
s{0,1}_axi_arsize  in  3  beat size
s{0,1}_axi_arburst  in  2  burst type
s{0,1}_axi_arprot  in  3  protection
s{0,1}_axi_arvalid  in  1  request valid
s{0,1}_axi_arready  out  1  request accepted
s{0,1}_axi_rdata  out  DATA_WIDTH  read data
s{0,1}_axi_rid  out  ID_WIDTH  read ID
s{0,1}_axi_rresp  out  2  response
s{0,1}_axi_rlast  out  1  last beat
s{0,1}_axi_rvalid  out  1  beat valid
s{0,1}_axi_rready  in  1  beat accepted
m_axi_araddr/arid/arlen/arsize/arburst/arprot  out  as above  downstream AR payload (registered)
m_axi_arvalid  out  1  downstream AR valid (registered)
m_axi_arready  in  1  downstream AR ready
m_axi_rdata/rid/rresp/rlast  in  as above  downstream R payload
m_axi_rvalid  in  1  downstream R valid
m_axi_rready  out  1  downstream R ready

Behaviour:
- Reset (rst_n=0 at clk edge):
  - state=IDLE, grant=0, last_grant=1, so port 0 wins first.
  - m_axi_arvalid=0, all AR payload registers cleared.
  - All s*_arready, s*_rvalid and m_axi_rready read 0.
- State IDLE:
  - sel = the only valid port. If both are valid, sel = the port other than last_grant.
  - s{sel}_arready=1 combinationally while IDLE and that port is valid. The other port's arready=0.
  - On the handshake edge: latch sel's AR payload into m_axi_* registers, set m_axi_arvalid=1, set grant=sel and last_grant=sel, go to AR.
  - No valid request: stay in IDLE with all outputs at 0.
- State AR:
  - m_axi_arvalid held with a stable payload until m_axi_arready=1.
  - On that edge: m_axi_arvalid=0, go to R. Downstream sees AR exactly 1 cycle after the upstream handshake.
  - All s*_arready=0 and m_axi_rready=0 in this state.
- State R (combinational pass-through, zero latency):
  - s{grant}_rvalid=m_axi_rvalid and s{grant}_r* = m_axi_r*.
  - m_axi_rready=s{grant}_rready.
  - Non-granted port: rvalid=0, payload driven 0.
  - Beat handshake with m_axi_rlast=1: return to IDLE on that edge. A new grant can handshake on the following cycle, giving a 1-cycle bubble.
  - rresp is forwarded unmodified; an error response does not end the burst early, only rlast does.
  - Arbitration is frozen during AR and R. A new arvalid on either port waits. An arvalid appearing on the granted port mid-burst is not accepted until IDLE.
- Both ports valid every cycle: grants strictly alternate 0,1,0,1,...
- arlen=0 (single beat): R state exits on its first beat.
- Reset mid-AR or mid-R: abort immediately with the outputs above; remaining downstream beats are not consumed. The system resets the downstream slave in the same reset domain.
- Upstream payload need only be stable in the handshake cycle; the AR payload is registered.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles with both arvalid=1 -> all arready/arvalid/rvalid/rready=0. First grant after release goes to port 0.
2. Single request: s1 araddr=0x1000, arid=3, arlen=0; m_arready=1 -> m_axi_arvalid rises 1 cycle after s1 handshake with araddr=0x1000, arid=3. One beat rdata=0xDEADBEEF, rlast=1 -> appears on s1 the same cycle; s0_rvalid stays 0.
3. Contention: both ports hold arvalid for 4 transactions of arlen=3 -> grant order 0,1,0,1. Each burst delivers 4 beats, rlast on the 4th, to the correct port only.
4. Backpressure: m_arready low for 5 cycles -> AR payload stable and arvalid held. During R, toggle s_rready 1,0,1,0 -> m_rready mirrors it and no beat is lost or duplicated.
5. Error response: a 2-beat burst with rresp=2'b10 on beat 0 -> both beats forwarded, return to IDLE only after the rlast beat.
6. Reset mid-burst: assert rst_n=0 after beat 1 of 4 -> next cycle in IDLE, m_rready=0, s*_rvalid=0. A fresh request then completes normally.
